// File: rtl/key_pkg.sv
// ============================================================================
// Module  : key_pkg
// Brief   : Shared state encoding, default parameters and width helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_LOCK  = 2'd2
   } state_t;

   localparam int DEF_KEY_W       = 8;
   localparam int DEF_NUM_KEYS    = 4;
   localparam int DEF_MAX_FAILS   = 3;
   localparam int DEF_LOCK_CYCLES = 16;

   // Bits needed to hold any value 0..max_val inclusive.
   function automatic int width_for(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int CNT_W  = width_for(DEF_NUM_KEYS);
   localparam int FAIL_W = width_for(DEF_MAX_FAILS);
   localparam int TMR_W  = width_for(DEF_LOCK_CYCLES);

endpackage

`default_nettype wire

// File: rtl/key_bank_if.sv
// ============================================================================
// Module  : key_bank_if
// Brief   : Key-entry strobes and status bus between data path and key_bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_bank_if
   import key_pkg::*;
#(
   parameter int KEY_W     = DEF_KEY_W,
   parameter int NUM_KEYS  = DEF_NUM_KEYS,
   parameter int MAX_FAILS = DEF_MAX_FAILS
)();

   logic [KEY_W-1:0]                    din;
   logic                                kset;
   logic                                kchk;
   logic                                kclr;
   logic [width_for(NUM_KEYS)-1:0]      num_keys;
   logic [NUM_KEYS*KEY_W-1:0]           keys;
   logic                                full;
   logic                                ovf;
   logic                                unlock;
   logic                                fail;
   logic                                locked;
   logic [width_for(MAX_FAILS)-1:0]     fail_cnt;

   modport master (
      output din, kset, kchk, kclr,
      input  num_keys, keys, full, ovf, unlock, fail, locked, fail_cnt
   );

   modport slave (
      input  din, kset, kchk, kclr,
      output num_keys, keys, full, ovf, unlock, fail, locked, fail_cnt
   );

endinterface

`default_nettype wire

// File: rtl/lockout_timer.sv
// ============================================================================
// Module  : lockout_timer
// Brief   : Loadable down-counter; done flags the final cycle of the count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lockout_timer
   import key_pkg::*;
#(
   parameter int LOAD_VAL = DEF_LOCK_CYCLES
)(
   input  wire logic dclk,
   input  wire logic reset,
   input  wire logic i_load,
   output logic      o_done
);

   localparam int               TW     = width_for(LOAD_VAL);
   localparam logic [TW-1:0]    c_load = TW'(LOAD_VAL);
   localparam logic [TW-1:0]    c_one  = TW'(1);

   logic [TW-1:0] r_count;

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= c_load;
      end else if (r_count != '0) begin
         r_count <= r_count - c_one;
      end
   end

   // Asserted on the last loaded cycle so the owner releases after exactly LOAD_VAL cycles.
   assign o_done = (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/key_bank.sv
// ============================================================================
// Module  : key_bank
// Brief   : Multi-slot key enrollment and sequence check with fail lockout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_bank
   import key_pkg::*;
#(
   parameter int KEY_W       = DEF_KEY_W,
   parameter int NUM_KEYS    = DEF_NUM_KEYS,
   parameter int MAX_FAILS   = DEF_MAX_FAILS,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
)(
   input  wire logic dclk,
   input  wire logic reset,
   key_bank_if.slave bus
);

   localparam int                 NK_W       = width_for(NUM_KEYS);
   localparam int                 FC_W       = width_for(MAX_FAILS);
   localparam logic [NK_W-1:0]    c_num_max  = NK_W'(NUM_KEYS);
   localparam logic [NK_W-1:0]    c_num_one  = NK_W'(1);
   localparam logic [FC_W-1:0]    c_fail_max = FC_W'(MAX_FAILS);
   localparam logic [FC_W-1:0]    c_fail_one = FC_W'(1);

   state_t                    r_state, w_state;
   logic [NUM_KEYS*KEY_W-1:0] r_keys, w_keys;
   logic [NK_W-1:0]           r_num, w_num;
   logic [NK_W-1:0]           r_idx, w_idx;
   logic                      r_mism, w_mism;
   logic [FC_W-1:0]           r_fcnt, w_fcnt;
   logic                      r_unlock, w_unlock;
   logic                      r_fail, w_fail;
   logic                      r_ovf, w_ovf;

   logic                      w_seq_done;
   logic                      w_seq_mism;
   logic                      w_tmr_load;
   logic                      w_tmr_done;
   logic [KEY_W-1:0]          w_slot;

   lockout_timer #(
      .LOAD_VAL (LOCK_CYCLES)
   ) u_timer (
      .dclk   (dclk),
      .reset  (reset),
      .i_load (w_tmr_load),
      .o_done (w_tmr_done)
   );

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_keys   <= '0;
         r_num    <= '0;
         r_idx    <= '0;
         r_mism   <= 1'b0;
         r_fcnt   <= '0;
         r_unlock <= 1'b0;
         r_fail   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_keys   <= w_keys;
         r_num    <= w_num;
         r_idx    <= w_idx;
         r_mism   <= w_mism;
         r_fcnt   <= w_fcnt;
         r_unlock <= w_unlock;
         r_fail   <= w_fail;
         r_ovf    <= w_ovf;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_keys     = r_keys;
      w_num      = r_num;
      w_idx      = r_idx;
      w_mism     = r_mism;
      w_fcnt     = r_fcnt;
      w_unlock   = 1'b0;
      w_fail     = 1'b0;
      w_ovf      = 1'b0;
      w_seq_done = 1'b0;
      w_seq_mism = 1'b0;
      w_tmr_load = 1'b0;
      w_slot     = (r_state == ST_CHECK) ? r_keys[int'(r_idx)*KEY_W +: KEY_W]
                                         : r_keys[KEY_W-1:0];

      // Lockout expiry runs regardless of strobes so kclr cannot shorten it.
      if (r_state == ST_LOCK && w_tmr_done) begin
         w_state = ST_IDLE;
         w_fcnt  = '0;
      end

      if (bus.kclr) begin
         w_keys = '0;
         w_num  = '0;
         w_idx  = '0;
         w_mism = 1'b0;
         if (r_state != ST_LOCK) begin
            w_state = ST_IDLE;
         end
      end else if (bus.kset) begin
         if (r_state == ST_CHECK) begin
            w_state = ST_IDLE;
            w_idx   = '0;
            w_mism  = 1'b0;
         end
         if (r_num < c_num_max) begin
            w_keys[int'(r_num)*KEY_W +: KEY_W] = bus.din;
            w_num                              = r_num + c_num_one;
         end else begin
            w_ovf = 1'b1;
         end
      end else if (bus.kchk) begin
         case (r_state)
            ST_IDLE: begin
               if (r_num != '0) begin
                  w_seq_mism = (bus.din != w_slot);
                  if (r_num == c_num_one) begin
                     w_seq_done = 1'b1;
                  end else begin
                     w_state = ST_CHECK;
                     w_idx   = c_num_one;
                     w_mism  = w_seq_mism;
                  end
               end
            end
            ST_CHECK: begin
               // Mismatches are accumulated, never acted on early, to keep timing constant.
               w_seq_mism = r_mism | (bus.din != w_slot);
               if (r_idx == r_num - c_num_one) begin
                  w_seq_done = 1'b1;
               end else begin
                  w_idx  = r_idx + c_num_one;
                  w_mism = w_seq_mism;
               end
            end
            default: ;
         endcase
      end

      if (w_seq_done) begin
         w_idx   = '0;
         w_mism  = 1'b0;
         w_state = ST_IDLE;
         if (!w_seq_mism) begin
            w_unlock = 1'b1;
            w_fcnt   = '0;
         end else begin
            w_fail = 1'b1;
            w_fcnt = (r_fcnt == c_fail_max) ? r_fcnt : r_fcnt + c_fail_one;
            if (w_fcnt == c_fail_max) begin
               w_state    = ST_LOCK;
               w_tmr_load = 1'b1;
            end
         end
      end
   end

   assign bus.num_keys = r_num;
   assign bus.keys     = r_keys;
   assign bus.full     = (r_num == c_num_max);
   assign bus.ovf      = r_ovf;
   assign bus.unlock   = r_unlock;
   assign bus.fail     = r_fail;
   assign bus.locked   = (r_state == ST_LOCK);
   assign bus.fail_cnt = r_fcnt;

endmodule

`default_nettype wire

// File: tb/tb_key_bank.sv
// ============================================================================
// Module  : tb_key_bank
// Brief   : Directed self-checking bench for key_bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_bank;

   logic dclk  = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 dclk = ~dclk;

   key_bank_if #(.KEY_W(8), .NUM_KEYS(4), .MAX_FAILS(3)) bus();

   key_bank #(
      .KEY_W       (8),
      .NUM_KEYS    (4),
      .MAX_FAILS   (3),
      .LOCK_CYCLES (16)
   ) dut (
      .dclk  (dclk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   task automatic do_set(input logic [7:0] k);
      bus.din  = k;
      bus.kset = 1'b1;
      tick();
      bus.kset = 1'b0;
   endtask

   task automatic do_chk(input logic [7:0] k);
      bus.din  = k;
      bus.kchk = 1'b1;
      tick();
      bus.kchk = 1'b0;
   endtask

   // Four-entry sequence, first key in the low byte; no pulse allowed before the last.
   task automatic run_seq(input string tag, input logic [31:0] s);
      for (int i = 0; i < 4; i++) begin
         do_chk(s[i*8 +: 8]);
         if (i < 3) check({tag, " early"}, 64'({bus.unlock, bus.fail}), 64'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " num"},    64'(bus.num_keys), 64'd0);
      check({tag, " keys"},   64'(bus.keys),     64'd0);
      check({tag, " flags"},  64'({bus.full, bus.ovf, bus.unlock, bus.fail, bus.locked}), 64'd0);
      check({tag, " fcnt"},   64'(bus.fail_cnt), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lock_len;
      logic saw_pulse;

      bus.din  = '0;
      bus.kset = 1'b0;
      bus.kchk = 1'b0;
      bus.kclr = 1'b0;
      #1 reset = 1'b0;
      #2;
      check_zero("reset");
      @(negedge dclk);
      reset = 1'b1;

      do_set(8'h11); do_set(8'h22); do_set(8'h33); do_set(8'h44);
      check("enroll num",  64'(bus.num_keys), 64'd4);
      check("enroll keys", 64'(bus.keys),     64'h44332211);
      check("enroll full", 64'(bus.full),     64'd1);
      do_set(8'h55);
      check("ovf pulse",   64'(bus.ovf),      64'd1);
      check("ovf keys",    64'(bus.keys),     64'h44332211);
      check("ovf num",     64'(bus.num_keys), 64'd4);
      tick();
      check("ovf one cyc", 64'(bus.ovf),      64'd0);

      run_seq("good", 32'h44332211);
      check("good unlock", 64'({bus.unlock, bus.fail}), 64'b10);
      check("good fcnt",   64'(bus.fail_cnt), 64'd0);
      tick();
      check("unlock one cyc", 64'(bus.unlock), 64'd0);

      run_seq("bad1", 32'h44339911);
      check("bad1 fail",   64'({bus.unlock, bus.fail}), 64'b01);
      check("bad1 fcnt",   64'(bus.fail_cnt), 64'd1);
      check("bad1 locked", 64'(bus.locked),   64'd0);
      tick();
      check("fail one cyc", 64'(bus.fail), 64'd0);

      run_seq("bad2", 32'h00332211);
      check("bad2 fcnt", 64'(bus.fail_cnt), 64'd2);
      run_seq("bad3", 32'h44332200);
      check("bad3 fail",   64'(bus.fail),     64'd1);
      check("bad3 fcnt",   64'(bus.fail_cnt), 64'd3);
      check("bad3 locked", 64'(bus.locked),   64'd1);

      lock_len  = 0;
      saw_pulse = 1'b0;
      while (bus.locked && lock_len < 40) begin
         lock_len++;
         bus.din  = 8'h11;
         bus.kchk = 1'b1;
         tick();
         if (bus.unlock || bus.fail) saw_pulse = 1'b1;
      end
      bus.kchk = 1'b0;
      check("lock length", 64'(lock_len),     64'd16);
      check("lock kchk ignored", 64'(saw_pulse), 64'd0);
      check("unlock fcnt", 64'(bus.fail_cnt), 64'd0);
      check("unlock lvl",  64'(bus.locked),   64'd0);
      run_seq("post-lock", 32'h44332211);
      check("post-lock unlock", 64'(bus.unlock), 64'd1);
      tick();

      do_chk(8'h11); do_chk(8'h22); do_set(8'h55);
      check("abort pulses", 64'({bus.ovf, bus.unlock, bus.fail}), 64'b100);
      check("abort keys",   64'(bus.keys), 64'h44332211);
      tick();
      check("abort no fail", 64'(bus.fail), 64'd0);
      run_seq("after abort", 32'h44332211);
      check("after abort unlock", 64'(bus.unlock), 64'd1);
      tick();

      bus.din  = 8'h55;
      bus.kset = 1'b1;
      bus.kchk = 1'b1;
      bus.kclr = 1'b1;
      tick();
      bus.kset = 1'b0;
      bus.kchk = 1'b0;
      bus.kclr = 1'b0;
      check("clr num",  64'(bus.num_keys), 64'd0);
      check("clr keys", 64'(bus.keys),     64'd0);
      check("clr flags", 64'({bus.full, bus.ovf}), 64'd0);

      do_set(8'hA5);
      check("one key num", 64'(bus.num_keys), 64'd1);
      do_chk(8'hA5);
      check("one key unlock", 64'({bus.unlock, bus.fail}), 64'b10);
      tick();
      do_chk(8'h5A);
      check("one key fail", 64'({bus.unlock, bus.fail}), 64'b01);
      check("one key fcnt", 64'(bus.fail_cnt), 64'd1);
      tick();

      do_set(8'h5A);
      do_chk(8'hA5);
      do_set(8'h77);
      check("abort store num",  64'(bus.num_keys), 64'd3);
      check("abort store keys", 64'(bus.keys),     64'h775AA5);
      check("abort store pulses", 64'({bus.ovf, bus.unlock, bus.fail}), 64'd0);
      tick();
      do_chk(8'hA5); do_chk(8'h5A); do_chk(8'h77);
      check("three key unlock", 64'({bus.unlock, bus.fail}), 64'b10);
      check("three key fcnt",   64'(bus.fail_cnt), 64'd0);
      tick();

      do_chk(8'hA5); do_chk(8'h5A);
      #3 reset = 1'b0;
      #1;
      check_zero("rst mid-check");
      @(negedge dclk);
      reset = 1'b1;
      do_chk(8'hA5);
      check("empty kchk", 64'({bus.unlock, bus.fail, bus.fail_cnt}), 64'd0);
      tick();
      check("empty kchk later", 64'({bus.unlock, bus.fail}), 64'd0);

      do_set(8'h01);
      do_chk(8'h02); do_chk(8'h02); do_chk(8'h02);
      check("lock2 locked", 64'({bus.locked, bus.fail_cnt}), 64'({1'b1, 2'd3}));
      tick(); tick(); tick();
      check("lock2 held", 64'(bus.locked), 64'd1);
      #3 reset = 1'b0;
      #1;
      check_zero("rst mid-lock");
      @(negedge dclk);
      reset = 1'b1;
      tick();
      check("after rst lock", 64'(bus.locked), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
